// File: rtl/rbot_moves_pkg.sv
// Shared move vocabulary for the solver, sequencer and motor scheduler.
// X/Xi pairs differ only in bit 0, so inverting a move is a single XOR.
package rbot_moves_pkg;

  localparam logic [3:0] MV_NOP = 4'd0;
  localparam logic [3:0] MV_R   = 4'd2;
  localparam logic [3:0] MV_RI  = 4'd3;
  localparam logic [3:0] MV_L   = 4'd4;
  localparam logic [3:0] MV_LI  = 4'd5;
  localparam logic [3:0] MV_F   = 4'd6;
  localparam logic [3:0] MV_FI  = 4'd7;
  localparam logic [3:0] MV_B   = 4'd8;
  localparam logic [3:0] MV_BI  = 4'd9;
  localparam logic [3:0] MV_U   = 4'd10;
  localparam logic [3:0] MV_UI  = 4'd11;
  localparam logic [3:0] MV_D   = 4'd12;
  localparam logic [3:0] MV_DI  = 4'd13;

  localparam int ROM_ADDR_W = 9;
  localparam int ROM_LEN_W  = 6;

  typedef struct packed {
    logic [ROM_ADDR_W-1:0] offset;
    logic [ROM_LEN_W-1:0]  len;
  } move_desc_t;

endpackage

// File: rtl/move_rom.sv
// Combinational batch table: batch index -> {offset, len}, address -> move code.
module move_rom
  import rbot_moves_pkg::*;
#(
  parameter int MOVE_W = 4,
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 9
) (
  input  logic [IDX_W-1:0]  batch_idx,
  input  logic [ADDR_W-1:0] addr,
  output move_desc_t        desc,
  output logic [MOVE_W-1:0] move
);

  // Batches 4 and up share a short two-move verification spin.
  always_comb begin
    desc = '{offset: ROM_ADDR_W'(15), len: ROM_LEN_W'(2)};
    case (int'(batch_idx))
      0: desc = '{offset: ROM_ADDR_W'(0),  len: ROM_LEN_W'(8)};
      1: desc = '{offset: ROM_ADDR_W'(8),  len: ROM_LEN_W'(3)};
      2: desc = '{offset: ROM_ADDR_W'(11), len: ROM_LEN_W'(0)};
      3: desc = '{offset: ROM_ADDR_W'(11), len: ROM_LEN_W'(4)};
      default: ;
    endcase
  end

  always_comb begin
    move = MOVE_W'(MV_NOP);
    case (int'(addr))
      0:  move = MOVE_W'(MV_R);
      1:  move = MOVE_W'(MV_U);
      2:  move = MOVE_W'(MV_RI);
      3:  move = MOVE_W'(MV_UI);
      4:  move = MOVE_W'(MV_F);
      5:  move = MOVE_W'(MV_D);
      6:  move = MOVE_W'(MV_FI);
      7:  move = MOVE_W'(MV_DI);
      8:  move = MOVE_W'(MV_FI);
      9:  move = MOVE_W'(MV_R);
      10: move = MOVE_W'(MV_RI);
      11: move = MOVE_W'(MV_U);
      12: move = MOVE_W'(MV_U);
      13: move = MOVE_W'(MV_LI);
      14: move = MOVE_W'(MV_B);
      15: move = MOVE_W'(MV_L);
      16: move = MOVE_W'(MV_BI);
      default: ;
    endcase
  end

endmodule

// File: rtl/move_sequencer.sv
// Streams one stored move batch over valid/ready, optionally reversed and
// direction-flipped so a batch can be undone.
module move_sequencer
  import rbot_moves_pkg::*;
#(
  parameter int MOVE_W      = 4,
  parameter int NUM_BATCHES = 52,
  parameter int MAX_LEN     = 32,
  parameter int ROM_DEPTH   = 512,
  parameter int IDX_W       = $clog2(NUM_BATCHES),
  parameter int LEN_W       = $clog2(MAX_LEN + 1),
  parameter int ADDR_W      = $clog2(ROM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  batch_idx,
  input  logic              invert,
  output logic              busy,
  output logic              move_valid,
  output logic [MOVE_W-1:0] move,
  output logic              move_last,
  input  logic              move_ready,
  output logic [LEN_W-1:0]  moves_left,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] offset_q;
  logic [LEN_W-1:0]  len_q;
  logic              inv_q;

  logic [ADDR_W-1:0] first_ptr;
  logic [ADDR_W-1:0] next_ptr;
  logic [ADDR_W-1:0] rom_addr;
  move_desc_t        rom_desc;
  logic [MOVE_W-1:0] rom_move;
  logic [MOVE_W-1:0] out_move;
  logic              idx_ok;
  logic              xfer;

  assign idx_ok    = int'(batch_idx) < NUM_BATCHES;
  assign xfer      = move_valid & move_ready;
  assign first_ptr = inv_q ? offset_q + ADDR_W'(len_q) - ADDR_W'(1) : offset_q;
  assign next_ptr  = inv_q ? ptr - ADDR_W'(1) : ptr + ADDR_W'(1);
  // The ROM is addressed one move ahead so the next move lands on the transfer edge.
  assign rom_addr  = (state == LOAD) ? first_ptr : next_ptr;
  assign out_move  = rom_move ^ {{(MOVE_W-1){1'b0}}, inv_q};

  move_rom #(
    .MOVE_W (MOVE_W),
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .batch_idx (batch_idx),
    .addr      (rom_addr),
    .desc      (rom_desc),
    .move      (rom_move)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      offset_q   <= '0;
      len_q      <= '0;
      inv_q      <= 1'b0;
      busy       <= 1'b0;
      move_valid <= 1'b0;
      move       <= '0;
      move_last  <= 1'b0;
      moves_left <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (idx_ok) begin
              offset_q <= ADDR_W'(rom_desc.offset);
              len_q    <= LEN_W'(rom_desc.len);
              inv_q    <= invert;
              busy     <= 1'b1;
              state    <= LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (len_q == '0) begin
            state <= FINISH;
          end else begin
            ptr        <= first_ptr;
            move       <= out_move;
            moves_left <= len_q;
            move_last  <= (len_q == LEN_W'(1));
            move_valid <= 1'b1;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            moves_left <= moves_left - LEN_W'(1);
            if (moves_left == LEN_W'(1)) begin
              move_valid <= 1'b0;
              move_last  <= 1'b0;
              done       <= 1'b1;
              state      <= FINISH;
            end else begin
              ptr       <= next_ptr;
              move      <= out_move;
              move_last <= (moves_left == LEN_W'(2));
            end
          end
        end
        FINISH: begin
          // An empty batch arrives here with done low and spends one cycle raising it.
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
            if (start) begin
              if (idx_ok) begin
                offset_q <= ADDR_W'(rom_desc.offset);
                len_q    <= LEN_W'(rom_desc.len);
                inv_q    <= invert;
                busy     <= 1'b1;
                state    <= LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
